// File: rtl/ram8.sv
// Eight-word register file: synchronous write through a 1-to-8 load demux,
// combinational read through an 8-to-1 mux, synchronous active-high clear.
module ram8 #(
  parameter int ADDRESS_WIDTH = 3,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0]    in,
  input  logic                     load,
  output logic [DATA_WIDTH-1:0]    out
);

  localparam int WORDS = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] words [WORDS];
  logic [WORDS-1:0]      word_load;

  // One-hot write decode; all lines stay low when load is deasserted.
  always_comb begin
    // NOTE: default assignment first so no path leaves word_load unassigned (no latch).
    word_load = '0;
    if (load) word_load[address] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the words are discrete registers, so clearing them all on reset is cheap and required.
      for (int i = 0; i < WORDS; i++) words[i] <= '0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        // NOTE: non-blocking so every word samples pre-edge values together.
        if (word_load[i]) words[i] <= in;
      end
    end
  end

  // Read is combinational with no bypass: a write shows up only after the edge.
  assign out = words[address];

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: a directed vector table plus hand-written
// sequences for read-during-write, reset priority and between-edge glitches.
module tb_ram8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic [15:0] in;
  logic        load;
  logic [15:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  ram8 #(.ADDRESS_WIDTH(3), .DATA_WIDTH(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .in      (in),
    .load    (load),
    .out     (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rst;
    bit          ld;
    logic [2:0]  addr;
    logic [15:0] data;
    bit          chk;   // compare out (before any edge) against exp
    logic [15:0] exp;
    bit          step;  // apply one rising edge with these inputs
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, bit rst, bit ld, logic [2:0] addr,
                              logic [15:0] data, bit chk, logic [15:0] exp, bit step);
    vec_t v;
    v.name = name; v.rst = rst; v.ld = ld; v.addr = addr; v.data = data;
    v.chk = chk; v.exp = exp; v.step = step;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: out=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [15:0] expected);
    load = 1'b0;
    reset = 1'b0;
    address = a;
    #1;
    check($sformatf("%s[a%0d]", name, a), out, expected);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; load = 1'b0; address = '0; in = '0;

    // Reset first, then every address must read zero.
    vecs.push_back(mk("reset", 1, 0, 3'd0, 16'h0000, 0, 16'h0000, 1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk("post_reset_zero", 0, 0, 3'(i), 16'h0000, 1, 16'h0000, 0));
    // Basic write/read.
    vecs.push_back(mk("wr_a0", 0, 1, 3'd0, 16'hA5A5, 0, 16'h0000, 1));
    vecs.push_back(mk("wr_a1", 0, 1, 3'd1, 16'h5A5A, 0, 16'h0000, 1));
    vecs.push_back(mk("rd_a0", 0, 0, 3'd0, 16'h0000, 1, 16'hA5A5, 0));
    vecs.push_back(mk("rd_a1", 0, 0, 3'd1, 16'h0000, 1, 16'h5A5A, 0));
    // Full word and isolation.
    vecs.push_back(mk("wr_a2", 0, 1, 3'd2, 16'hFFFF, 0, 16'h0000, 1));
    vecs.push_back(mk("rd_a2_full", 0, 0, 3'd2, 16'h0000, 1, 16'hFFFF, 0));
    vecs.push_back(mk("iso_a0", 0, 0, 3'd0, 16'h0000, 1, 16'hA5A5, 0));
    vecs.push_back(mk("iso_a1", 0, 0, 3'd1, 16'h0000, 1, 16'h5A5A, 0));
    for (int i = 3; i < 8; i++)
      vecs.push_back(mk("iso_zero", 0, 0, 3'(i), 16'h0000, 1, 16'h0000, 0));
    // No write without load, over several edges.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("noload_a0", 0, 0, 3'd0, 16'h1234, 1, 16'hA5A5, 1));
    vecs.push_back(mk("noload_a0_after", 0, 0, 3'd0, 16'h1234, 1, 16'hA5A5, 0));

    foreach (vecs[i]) begin
      if (vecs[i].step) @(negedge clk);
      reset = vecs[i].rst; load = vecs[i].ld; address = vecs[i].addr; in = vecs[i].data;
      #1;
      if (vecs[i].chk) check($sformatf("%s[a%0d]", vecs[i].name, vecs[i].addr), out, vecs[i].exp);
      if (vecs[i].step) begin
        @(posedge clk);
        #1;
      end
    end

    // Read-during-write: old value before the edge, new value after.
    @(negedge clk);
    address = 3'd1; in = 16'h0F0F; load = 1'b1;
    #1 check("rdw_before", out, 16'h5A5A);
    @(posedge clk);
    #1 check("rdw_after", out, 16'h0F0F);
    load = 1'b0;

    // Reset pulse entirely between edges has no effect.
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    read_check("reset_glitch", 3'd1, 16'h0F0F);
    read_check("reset_glitch", 3'd0, 16'hA5A5);

    // Load/in toggled between edges has no effect.
    @(negedge clk);
    address = 3'd3; in = 16'hDEAD; load = 1'b1;
    #1 load = 1'b0; in = 16'hBEEF;
    @(posedge clk);
    #1;
    read_check("load_glitch", 3'd3, 16'h0000);

    // Reset wins over a simultaneous write; everything clears.
    @(negedge clk);
    reset = 1'b1; load = 1'b1; address = 3'd5; in = 16'hBEEF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) read_check("reset_prio", 3'(i), 16'h0000);

    // Exhaustive sweep: word i holds 0x1111*i.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset = 1'b0; load = 1'b1; address = 3'(i); in = 16'(16'h1111 * i);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 8; i++) read_check("sweep", 3'(i), 16'(16'h1111 * i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
